// File: rtl/wm8731_pkg.sv
// Shared types and constants for the WM8731 I2C init sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wm8731_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_START, ST_BIT, ST_STOP, ST_GAP, ST_DONE, ST_ERROR
  } state_e;

  localparam logic [6:0] REG_LINVOL = 7'h00;
  localparam logic [6:0] REG_RINVOL = 7'h01;
  localparam logic [6:0] REG_LHPOUT = 7'h02;
  localparam logic [6:0] REG_RHPOUT = 7'h03;
  localparam logic [6:0] REG_APANA  = 7'h04;
  localparam logic [6:0] REG_APDIG  = 7'h05;
  localparam logic [6:0] REG_PWR    = 7'h06;
  localparam logic [6:0] REG_IFACE  = 7'h07;
  localparam logic [6:0] REG_SRATE  = 7'h08;
  localparam logic [6:0] REG_ACTIVE = 7'h09;
  localparam logic [6:0] REG_RESET  = 7'h0F;

  localparam int INIT_LEN = 11;

  // Table word layout: {reg_addr[6:0], data[8:0]}.
  function automatic logic [15:0] cfg_word(input logic [6:0] ra, input logic [8:0] d);
    return {ra, d};
  endfunction

  // Default init table, fed to the sequencer's cfg_data by the board top.
  function automatic logic [15:0] init_word(input int unsigned i);
    case (i)
      0:       return cfg_word(REG_RESET,  9'h000);
      1:       return cfg_word(REG_PWR,    9'h000);
      2:       return cfg_word(REG_LINVOL, 9'h017);
      3:       return cfg_word(REG_RINVOL, 9'h017);
      4:       return cfg_word(REG_LHPOUT, 9'h079);
      5:       return cfg_word(REG_RHPOUT, 9'h079);
      6:       return cfg_word(REG_APANA,  9'h012);
      7:       return cfg_word(REG_APDIG,  9'h000);
      8:       return cfg_word(REG_IFACE,  9'h00A);
      9:       return cfg_word(REG_SRATE,  9'h000);
      default: return cfg_word(REG_ACTIVE, 9'h001);
    endcase
  endfunction

endpackage

// File: rtl/i2c_phase_timer.sv
// Quarter-period counter plus phase index for the I2C sequencer.
// Latency: tc_o asserts on the last cycle of each CLK_DIV-cycle quarter.
// Backpressure: hold_i freezes the counter (clock stretching); clr_i restarts at phase 0.
module i2c_phase_timer #(
  parameter int CLK_DIV = 250,
  parameter int PH_W    = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            clr_i,
  input  logic            hold_i,
  output logic            tc_o,
  output logic [PH_W-1:0] ph_o
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PH_W-1:0] ph_q, ph_d;

  assign tc_o = (cnt_q == CW'(CLK_DIV - 1)) && !hold_i;
  assign ph_o = ph_q;

  // Next count: clear wins, terminal count advances the phase, hold freezes.
  always_comb begin
    cnt_d = cnt_q;
    ph_d  = ph_q;
    if (clr_i) begin
      cnt_d = '0;
      ph_d  = '0;
    end else if (tc_o) begin
      cnt_d = '0;
      ph_d  = ph_q + PH_W'(1);
    end else if (!hold_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
      ph_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      ph_q  <= ph_d;
    end
  end

endmodule

// File: rtl/wm8731_i2c_init.sv
// WM8731 register-init sequencer: writes NUM_REGS table words as 3-byte I2C writes, retrying on NACK.
// Latency: one ACKed write takes 2 + (2 + 108 + 3 + GAP_Q) * CLK_DIV cycles; done/error one cycle later.
// Backpressure: I2C_CLOCK_STRETCH_EN holds SCL-high quarters while a slave keeps SCL low; else fixed timing.
module wm8731_i2c_init
  import wm8731_pkg::*;
#(
  parameter int         NUM_REGS  = 11,
  parameter int         CLK_DIV   = 250,
  parameter logic [6:0] DEV_ADDR  = 7'h1A,
  parameter int         MAX_RETRY = 3,
  parameter int         GAP_Q     = 4,
  localparam int        IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] cfg_idx,
  input  logic [15:0]      cfg_data,
  input  logic             i2c_scl_i,
  output logic             i2c_scl_o,
  output logic             i2c_scl_t,
  input  logic             i2c_sda_i,
  output logic             i2c_sda_o,
  output logic             i2c_sda_t
);

  localparam int RTY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int PH_MAX = (GAP_Q > 4) ? GAP_Q : 4;
  localparam int PH_W   = $clog2(PH_MAX);

  state_e           state_q, state_d;
  logic             fcyc_q, fcyc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [RTY_W-1:0] rty_q, rty_d;
  logic [23:0]      sh_q, sh_d;
  logic [3:0]       pos_q, pos_d;
  logic [1:0]       byte_q, byte_d;
  logic             nack_q, nack_d;
  logic             busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic             scl_t, sda_t;

  logic             tc, timed, ph_done, tmr_clr, hold;
  logic [PH_W-1:0]  ph, last_ph;

  i2c_phase_timer #(.CLK_DIV(CLK_DIV), .PH_W(PH_W)) u_timer (
    .clk    (clk),
    .rstn   (rstn),
    .clr_i  (tmr_clr),
    .hold_i (hold),
    .tc_o   (tc),
    .ph_o   (ph)
  );

`ifdef I2C_CLOCK_STRETCH_EN
  assign hold = ((state_q == ST_BIT) || (state_q == ST_STOP)) && (ph == PH_W'(1)) && !i2c_scl_i;
`else
  logic unused_scl;
  assign unused_scl = i2c_scl_i;
  assign hold       = 1'b0;
`endif

  // Final quarter of each timed state; the timer restarts at phase 0 after it.
  always_comb begin
    last_ph = PH_W'(GAP_Q - 1);
    timed   = 1'b1;
    case (state_q)
      ST_START: last_ph = PH_W'(1);
      ST_BIT:   last_ph = PH_W'(3);
      ST_STOP:  last_ph = PH_W'(2);
      ST_GAP:   last_ph = PH_W'(GAP_Q - 1);
      default:  timed   = 1'b0;
    endcase
  end

  assign ph_done = tc && (ph == last_ph);
  assign tmr_clr = !timed || ph_done;

  // Sequencer next-state and open-drain line decode.
  always_comb begin
    state_d = state_q;
    fcyc_d  = 1'b0;
    idx_d   = idx_q;
    rty_d   = rty_q;
    sh_d    = sh_q;
    pos_d   = pos_q;
    byte_d  = byte_q;
    nack_d  = nack_q;
    busy_d  = busy_q;
    done_d  = done_q;
    error_d = error_q;
    scl_t   = 1'b1;
    sda_t   = 1'b1;
    unique case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_FETCH;
        idx_d   = '0;
        rty_d   = '0;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        error_d = 1'b0;
      end
      ST_FETCH: begin
        // Cycle 0 presents cfg_idx; the table answers one cycle later.
        fcyc_d = !fcyc_q;
        nack_d = 1'b0;
        pos_d  = '0;
        byte_d = '0;
        if (fcyc_q) begin
          sh_d    = {DEV_ADDR, 1'b0, cfg_data};
          state_d = ST_START;
        end
      end
      ST_START: begin
        sda_t = 1'b0;
        scl_t = (ph == PH_W'(0));
        if (ph_done) state_d = ST_BIT;
      end
      ST_BIT: begin
        scl_t = (ph == PH_W'(1)) || (ph == PH_W'(2));
        sda_t = (pos_q == 4'd8) ? 1'b1 : sh_q[23];
        if (tc && (ph == PH_W'(2)) && (pos_q == 4'd8)) nack_d = i2c_sda_i;
        if (ph_done) begin
          if (pos_q == 4'd8) begin
            pos_d  = '0;
            byte_d = byte_q + 2'd1;
            if (nack_q || (byte_q == 2'd2)) state_d = ST_STOP;
          end else begin
            pos_d = pos_q + 4'd1;
            sh_d  = {sh_q[22:0], 1'b0};
          end
        end
      end
      ST_STOP: begin
        scl_t = (ph != PH_W'(0));
        sda_t = (ph == PH_W'(2));
        if (ph_done) state_d = ST_GAP;
      end
      ST_GAP: if (ph_done) begin
        if (!nack_q) begin
          rty_d = '0;
          if (idx_q == IDX_W'(NUM_REGS - 1)) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_FETCH;
          end
        end else if (rty_q < RTY_W'(MAX_RETRY)) begin
          rty_d   = rty_q + RTY_W'(1);
          state_d = ST_FETCH;
        end else begin
          state_d = ST_ERROR;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      ST_ERROR: begin
        error_d = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset releases both lines at once through the decode above.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      fcyc_q  <= 1'b0;
      idx_q   <= '0;
      rty_q   <= '0;
      sh_q    <= '0;
      pos_q   <= '0;
      byte_q  <= '0;
      nack_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fcyc_q  <= fcyc_d;
      idx_q   <= idx_d;
      rty_q   <= rty_d;
      sh_q    <= sh_d;
      pos_q   <= pos_d;
      byte_q  <= byte_d;
      nack_q  <= nack_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign cfg_idx   = idx_q;
  assign i2c_scl_o = 1'b0;
  assign i2c_sda_o = 1'b0;
  assign i2c_scl_t = scl_t;
  assign i2c_sda_t = sda_t;

endmodule

// File: tb/tb_wm8731_i2c_init.sv
// Bench for wm8731_i2c_init: pull-up bus, I2C slave/monitor and a byte-level scoreboard.
// Latency: checks per-write timing of 2 + (2 + 108 + 3 + GAP_Q) * CLK_DIV cycles.
// Backpressure: slave may NACK or (with I2C_CLOCK_STRETCH_EN) stretch SCL.
module tb_wm8731_i2c_init;

  localparam int         NREG = 2;
  localparam int         CDIV = 4;
  localparam int         GAPQ = 4;
  localparam int         MAXR = 3;
  localparam logic [6:0] DEV  = 7'h1A;
  localparam int         T_WR = 2 + (2 + 108 + 3 + GAPQ) * CDIV;

  logic        clk = 1'b0, rstn = 1'b0, start = 1'b0;
  logic        busy, done, error;
  logic [0:0]  cfg_idx;
  logic [15:0] cfg_data = 16'h0;
  logic        scl_o, sda_o, scl_t, sda_t, scl_i, sda_i;
  logic        slv_sda_low = 1'b0, slv_scl_low = 1'b0;
  logic [15:0] tbl [NREG];
  logic [7:0]  exp_q [$];
  int          cyc = 0, tests = 0, fails = 0;
  int          nack_byte = 3, nack_cnt = 0, run_att0 = 0, slv_att = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Open-drain bus with pull-ups.
  assign scl_i = scl_t & ~slv_scl_low;
  assign sda_i = sda_t & ~slv_sda_low;

  // Register table: word valid one cycle after the index changes.
  always @(posedge clk) cfg_data <= tbl[cfg_idx];

  wm8731_i2c_init #(.NUM_REGS(NREG), .CLK_DIV(CDIV), .DEV_ADDR(DEV), .MAX_RETRY(MAXR), .GAP_Q(GAPQ)) dut (
    .clk(clk), .rstn(rstn), .start(start), .busy(busy), .done(done), .error(error),
    .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .i2c_scl_i(scl_i), .i2c_scl_o(scl_o), .i2c_scl_t(scl_t),
    .i2c_sda_i(sda_i), .i2c_sda_o(sda_o), .i2c_sda_t(sda_t)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Slave + monitor: decodes START and bytes, answers ACK/NACK, scores each byte.
  logic pscl = 1'b1, psda = 1'b1, ack_ph = 1'b0;
  int   bcnt = 0, bnum = 0, cur_att = 0;
  logic [7:0] sh = 8'h0;
  always @(negedge clk) begin
    if (!rstn) begin
      pscl = 1'b1; psda = 1'b1; ack_ph = 1'b0; bcnt = 0; bnum = 0; slv_sda_low = 1'b0;
    end else begin
      if (scl_i && pscl && psda && !sda_i) begin
        bcnt = 0; bnum = 0; ack_ph = 1'b0; cur_att = slv_att - run_att0; slv_att++;
      end else if (scl_i && !pscl && !ack_ph && bcnt < 8) begin
        sh = {sh[6:0], sda_i};
        bcnt++;
      end else if (!scl_i && pscl) begin
        if (ack_ph) begin
          ack_ph = 1'b0; slv_sda_low = 1'b0; bcnt = 0; bnum++;
        end else if (bcnt == 8) begin
          ack_ph = 1'b1;
          slv_sda_low = !((cur_att < nack_cnt) && (bnum == nack_byte));
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL bus_byte: got %02h, expected no byte", sh);
          end else begin
            chk("bus_byte", {24'h0, sh}, {24'h0, exp_q.pop_front()});
          end
        end
      end
      pscl = scl_i; psda = sda_i;
    end
  end

  task automatic do_start(output int t0);
    @(negedge clk);
    start = 1'b1;
    t0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait for done/error, pulsing a stray start mid-run that must be ignored.
  task automatic wait_end(input int t0, input int budget, input int poke, output int el);
    el = -1;
    for (int i = 0; i < budget; i++) begin
      start = (i == poke);
      @(negedge clk);
      if (done || error) begin el = cyc - t0; break; end
    end
    start = 1'b0;
    if (el < 0) begin
      tests++; fails++;
      $display("FAIL timeout: no done/error within %0d cycles", budget);
    end
  endtask

  // Reference: each attempt shows bytes up to and including a NACKed one.
  task automatic model(output int n_att, output bit exp_err, output int fail_e);
    logic [7:0] bytes [3];
    int att = 0, tries, k;
    exp_err = 1'b0; fail_e = 0;
    for (int e = 0; e < NREG && !exp_err; e++) begin
      bytes[0] = {DEV, 1'b0}; bytes[1] = tbl[e][15:8]; bytes[2] = tbl[e][7:0];
      tries = 0;
      while (1) begin
        k = (att < nack_cnt) ? nack_byte : 3;
        for (int b = 0; b < 3 && b <= k; b++) exp_q.push_back(bytes[b]);
        att++;
        if (k == 3) break;
        tries++;
        if (tries > MAXR) begin exp_err = 1'b1; fail_e = e; break; end
      end
    end
    n_att = att;
  endtask

  task automatic run(input string nm, input int nb, input int nc, input bit stretch);
    int t0, el, n_att, fail_e, extra;
    bit exp_err;
    nack_byte = nb; nack_cnt = nc; run_att0 = slv_att;
    extra = 0;
    model(n_att, exp_err, fail_e);
    do_start(t0);
    chk({nm, "_busy_rise"}, {31'h0, busy}, 1);
    chk({nm, "_done_clr"}, {31'h0, done}, 0);
    if (stretch) begin
      extra = 20;
      fork
        begin
          repeat (155) @(posedge clk);
          #1 slv_scl_low = 1'b1;
          repeat (23) @(posedge clk);
          #1 slv_scl_low = 1'b0;
        end
      join_none
    end
    wait_end(t0, 8000, $urandom_range(20, 400), el);
    chk({nm, "_done"}, {31'h0, done}, {31'h0, !exp_err});
    chk({nm, "_error"}, {31'h0, error}, {31'h0, exp_err});
    chk({nm, "_busy_fall"}, {31'h0, busy}, 0);
    if (exp_err) chk({nm, "_idx"}, {31'h0, cfg_idx}, fail_e);
    if (nb == 3 || nc == 0) chk({nm, "_cycles"}, el, NREG * T_WR + 1 + extra);
    chk({nm, "_starts"}, slv_att - run_att0, n_att);
    chk({nm, "_q_empty"}, exp_q.size(), 0);
  endtask

  task automatic reset_mid();
    int t0;
    nack_byte = 3; nack_cnt = 0; run_att0 = slv_att;
    exp_q.push_back({DEV, 1'b0});   // bit 12 lies in byte 1: only byte 0 completes
    do_start(t0);
    repeat (203) @(posedge clk);    // Q0 of bit 12: SCL driven low
    #1;
    chk("rst_pre_scl", {31'h0, scl_t}, 0);
    rstn = 1'b0;
    #1;
    chk("rst_scl_t", {31'h0, scl_t}, 1);
    chk("rst_sda_t", {31'h0, sda_t}, 1);
    chk("rst_busy", {31'h0, busy}, 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    chk("rst_starts", slv_att - run_att0, 1);
    chk("rst_q_empty", exp_q.size(), 0);
  endtask

  initial begin
    int low;
    tbl[0] = 16'h1E00; tbl[1] = 16'h1201;
    repeat (3) @(negedge clk);
    chk("reset_scl_t", {31'h0, scl_t}, 1);
    chk("reset_sda_t", {31'h0, sda_t}, 1);
    chk("reset_scl_o", {31'h0, scl_o}, 0);
    chk("reset_sda_o", {31'h0, sda_o}, 0);
    chk("reset_flags", {29'h0, busy, done, error}, 0);
    chk("reset_idx", {31'h0, cfg_idx}, 0);
    rstn = 1'b1;
    low = 0;
    repeat (100) begin
      @(negedge clk);
      if (!scl_i || !sda_i || busy) low++;
    end
    chk("idle_lines", low, 0);

    run("ack_all", 3, 0, 1'b0);
    run("retry", 0, 2, 1'b0);
    run("exhaust", 1, 99, 1'b0);
    tbl[0] = 16'($urandom); tbl[1] = 16'($urandom);
    reset_mid();
    run("after_rst", 3, 0, 1'b0);
`ifdef I2C_CLOCK_STRETCH_EN
    run("stretch", 3, 0, 1'b1);
`endif
    for (int r = 0; r < 4; r++) begin
      tbl[0] = 16'($urandom); tbl[1] = 16'($urandom);
      run("rand", $urandom_range(0, 3), $urandom_range(0, 5), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wm8731_i2c_init.md
# wm8731_i2c_init

Parametrised I2C register-init sequencer for the WM8731 audio codec PMOD. After a `start` pulse it fetches NUM_REGS 16-bit words from an external table, one at a time. Each word goes out as a 3-byte I2C write: device address, then the high byte, then the low byte. The block checks ACK on every byte and retries an entry when the codec NACKs. It sits in `top`, beside the audio datapath, and drives the open-drain `i2c_scl_*` / `i2c_sda_*` triplets that the board wrapper resolves to tristate pads.

## Interface
- NUM_REGS, 11: number of table entries to write; must be at least 1.
- CLK_DIV, 250: clk cycles per SCL quarter-period; must be at least 2. The default gives 100 kHz SCL at 100 MHz.
- DEV_ADDR, 7'h1A: 7-bit I2C address of the codec (CSB low).
- MAX_RETRY, 3: retries per entry after a NACK.
- GAP_Q, 4: bus-free time between transactions, in quarters.

Ports (clock and reset first):
- clk  in  1  system clock.
- rstn  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to begin the sequence.
- busy  out  1  high from the cycle after `start` is accepted until `done` or `error`.
- done  out  1  sticky: all entries ACKed. Cleared when `start` is accepted.
- error  out  1  sticky: retries exhausted. Cleared when `start` is accepted.
- cfg_idx  out  $clog2(NUM_REGS)  table index being fetched.
- cfg_data  in  16  table word: {reg_addr[6:0], data[8:0]}. Valid one cycle after `cfg_idx` changes.
- i2c_scl_i / i2c_sda_i  in  1  pad readback.
- i2c_scl_o / i2c_sda_o  out  1  held at constant 0.
- i2c_scl_t / i2c_sda_t  out  1  1 = release the line (pulled high), 0 = drive it low.

## Operation
- States: IDLE → FETCH → START → BIT → STOP → GAP, then back to FETCH or to DONE, or from GAP to ERROR.
- IDLE: both lines released. `start` is sampled here only; it is ignored in every other state.
- FETCH (2 cycles):
  - Cycle 0: drive `cfg_idx`.
  - Cycle 1: latch `cfg_data`.
  - Build the shift sequence {DEV_ADDR,1'b0}, cfg_data[15:8], cfg_data[7:0].
- START (2 quarters):
  - Q0: SDA low while SCL is high.
  - Q1: SCL low.
- BIT (27 bits = 3 × (8 data + 1 ACK), 4 quarters each):
  - Q0: SCL low; set SDA. Data bits go out MSB first; the ACK slot releases SDA.
  - Q1: release SCL.
  - Q2: SCL high. On the last cycle of Q2 of an ACK slot, sample `i2c_sda_i`; 1 = NACK.
  - Q3: SCL low.
  - On a NACK, skip the remaining bits and go to STOP.
- STOP (3 quarters):
  - Q0: SDA low.
  - Q1: release SCL.
  - Q2: release SDA.
- GAP (GAP_Q quarters), lines released, then one of:
  - ACKed: increment the index and clear the retry counter. If the entry was index NUM_REGS-1, go to DONE; otherwise go to FETCH.
  - NACKed, retry counter below MAX_RETRY: increment the counter and go to FETCH at the same index.
  - NACKed, retries exhausted: go to ERROR.
- DONE / ERROR: set the matching sticky flag, clear `busy`, return to IDLE.
- A new `start` in IDLE clears `done`, `error`, the index and the retry counter.

## Timing
- Reset values, asynchronous:
  - `i2c_scl_t` = `i2c_sda_t` = 1; `i2c_scl_o` = `i2c_sda_o` = 0.
  - `busy` = `done` = `error` = 0; `cfg_idx` = 0; state IDLE.
- Quarter counter runs 0..CLK_DIV-1; a phase advances on terminal count.
- `busy` rises one cycle after `start` is sampled.
- One ACKed write costs 2 + (2 + 108 + 3 + GAP_Q)·CLK_DIV cycles. With CLK_DIV=4 and GAP_Q=4 that is 470 cycles.
- Reset mid-transaction releases both lines immediately. No STOP is issued; the next `start` re-runs from index 0.
- `start` asserted in the same cycle the block enters IDLE from DONE or ERROR is not sampled. `start` is sampled from the following cycle.

## Configuration
- `I2C_CLOCK_STRETCH_EN` defined:
  - In BIT Q1 and STOP Q1, the quarter counter holds until `i2c_scl_i` reads 1.
  - The wait is unbounded.
- Not defined: `i2c_scl_i` is ignored and all phases are fixed length.

## Structure
- Package `wm8731_pkg` holds:
  - the state enum;
  - the WM8731 register-address constants (LINVOL=0x00 … RESET=0x0F, ACTIVE=0x09);
  - the default init table (used by `top`).
- Sub-module `i2c_phase_timer`: quarter counter plus phase index, with the stretch hold input. The FSM lives in the parent.

## Test plan
Bench setup: CLK_DIV=4, GAP_Q=4, with a pull-up model on both pads.
- Reset held, then released → both `_t`=1, `busy`=0, `done`=0. Lines stay high for 100 cycles without `start`.
- Open-drain wiring and bus-monitor decoding:
  - Slave model ACKs all bytes; NUM_REGS=2; table {16'h1E00, 16'h1201}.
  - Required: monitor decodes bytes 0x34,0x1E,0x00 then 0x34,0x12,0x01.
  - Required: `done`=1 at cycle 2·470+1 after `start`.
- Retry then success:
  - Slave NACKs the address byte twice, then ACKs.
  - Required: three START conditions for entry 0, `error`=0, `done`=1.
- Retries exhausted:
  - Slave always NACKs the second byte.
  - Required: exactly 4 attempts, then `error`=1, `done`=0, `busy`=0. `cfg_idx` stays 0.
- Reset mid-write:
  - `rstn` low during bit 12.
  - Required: `_t` lines go to 1 in the same cycle.
  - Required: a later `start` re-sends entry 0.
- Clock stretching, `I2C_CLOCK_STRETCH_EN`:
  - Slave holds SCL low 20 cycles in bit 9.
  - Required: the transaction is 20 cycles longer and decoded data is unchanged.
